// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - packet-locked round-robin arbiter feeding one FIFO write port
//
// Purpose:
//   NREQ requesters compete for a single FIFO write port. A winner keeps the
//   port for the whole packet (until an accepted beat carries req_last). At
//   least one idle cycle separates packets. The next search starts just above
//   the previous owner, so grants rotate fairly.
//
// Optional feature:
//   WARB_BURST_LIMIT_EN - when defined, a grant is also released after
//   MAX_BURST accepted beats. The owner re-competes later and resumes its
//   packet when it is granted again.
//
// Ports:
//   wclk        in   write-domain clock, rising edge
//   wrst        in   asynchronous active-high reset
//   req         in   [NREQ]        per-requester beat valid
//   req_data    in   [NREQ*DSIZE]  beat data, slice i*DSIZE +: DSIZE
//   req_last    in   [NREQ]        final beat of requester i's packet
//   ack         out  [NREQ]        combinational beat-accepted, owner only
//   gnt         out  [NREQ]        registered one-hot owner, zero when idle
//   fifo_wdata  out  [DSIZE]       owner's data to FIFO
//   fifo_write  out                FIFO write strobe
//   fifo_full   in                 FIFO full, wclk domain
//   busy        out                a packet currently owns the port

module fifo_write_arbiter #(
    parameter int DSIZE     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         gnt,
    output logic [DSIZE-1:0]        fifo_wdata,
    output logic                    fifo_write,
    input  logic                    fifo_full,
    output logic                    busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_owner_q, last_owner_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic            accept;
    logic            burst_done;
    logic            pkt_done;

    // Rotating search: candidates last_owner+1 .. last_owner+NREQ, wrapped
    // by a single conditional subtract instead of a modulo.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            logic [IW:0] cand;
            cand = {1'b0, last_owner_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!pick_found && req[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    // A beat moves only for the owner and only when the FIFO has room;
    // requests from non-owners never reach this term.
    assign accept = (state_q == S_LOCKED) && req[owner_q] && !fifo_full;

`ifdef WARB_BURST_LIMIT_EN
    // Counter holds beats already taken, so this accept is the MAX_BURST-th.
    assign burst_done = (beat_cnt_q == CW'(MAX_BURST - 1));
`else
    assign burst_done = 1'b0;
`endif

    assign pkt_done = accept && (req_last[owner_q] || burst_done);

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d    = S_LOCKED;
                    owner_d    = pick_idx;
                    gnt_d      = NREQ'(1) << pick_idx;
                    beat_cnt_d = '0;
                end
            end
            S_LOCKED: begin
                if (accept) begin
                    // Saturate so unlimited packets cannot wrap the count.
                    if (beat_cnt_q != {CW{1'b1}}) begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                    if (pkt_done) begin
                        state_d      = S_IDLE;
                        gnt_d        = '0;
                        last_owner_d = owner_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= IW'(NREQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Every strobe is qualified by the registered state, which reset clears
    // asynchronously, so writes stop the moment wrst rises.
    assign fifo_write = accept;
    assign ack        = accept ? gnt_q : '0;
    assign gnt        = gnt_q;
    assign busy       = (state_q == S_LOCKED);
    assign fifo_wdata = req_data[owner_q*DSIZE +: DSIZE];

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

    localparam int NREQ      = 4;
    localparam int DSIZE     = 8;
    localparam int MAX_BURST = 4;

    logic                  wclk = 1'b0;
    logic                  wrst;
    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       gnt;
    logic [DSIZE-1:0]      fifo_wdata;
    logic                  fifo_write;
    logic                  fifo_full;
    logic                  busy;

    fifo_write_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
        .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .req_last(req_last),
        .ack(ack), .gnt(gnt), .fifo_wdata(fifo_wdata), .fifo_write(fifo_write),
        .fifo_full(fifo_full), .busy(busy)
    );

    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-requester packet source: {last, data} beats.
    logic [8:0] pq [NREQ][$];
    bit         en [NREQ];

    // Reference: owner (-1 = none), previous owner, beats this grant.
    int m_owner, m_last, m_cnt;
    logic [NREQ-1:0] exp_gnt, exp_ack;
    logic            exp_write, exp_busy;
    logic [7:0]      exp_wdata;

    logic [7:0]      wlog[$];
    int              wcyc[$];
    logic [NREQ-1:0] glog[$];
    logic [NREQ-1:0] prev_gnt;
    int              cyc;

    task automatic model_reset();
        m_owner = -1; m_last = NREQ - 1; m_cnt = 0;
    endtask

    task automatic model_expect();
        exp_gnt = '0; exp_ack = '0; exp_write = 1'b0; exp_wdata = '0;
        if (m_owner >= 0) begin
            exp_gnt   = 4'b0001 << m_owner;
            exp_write = req[m_owner] && !fifo_full;
            exp_ack   = exp_write ? exp_gnt : 4'b0000;
            exp_wdata = req_data[m_owner*DSIZE +: DSIZE];
        end
        exp_busy = (m_owner >= 0);
    endtask

    task automatic model_advance();
        bit found;
        int c;
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                c = (m_last + k) % NREQ;
                if (!found && req[c]) begin
                    found = 1'b1; m_owner = c; m_cnt = 0;
                end
            end
        end else if (exp_write) begin
            void'(pq[m_owner].pop_front());
            m_cnt++;
`ifdef WARB_BURST_LIMIT_EN
            if (req_last[m_owner] || m_cnt == MAX_BURST) begin
`else
            if (req_last[m_owner]) begin
`endif
                m_last = m_owner; m_owner = -1;
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            logic [8:0] b;
            if (en[i] && pq[i].size() > 0) begin
                b = pq[i][0]; req[i] = 1'b1;
            end else begin
                b = 9'($urandom); req[i] = 1'b0;
            end
            req_data[i*DSIZE +: DSIZE] = b[7:0];
            req_last[i] = b[8];
        end
    endtask

    task automatic log_step();
        if (fifo_write) begin wlog.push_back(fifo_wdata); wcyc.push_back(cyc); end
        if (gnt != 0 && prev_gnt == 0) glog.push_back(gnt);
        prev_gnt = gnt;
        cyc++;
    endtask

    task automatic clear_logs();
        wlog.delete(); wcyc.delete(); glog.delete(); prev_gnt = '0; cyc = 0;
    endtask

    task automatic do_reset();
        wrst = 1'b1; fifo_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin pq[i].delete(); en[i] = 1'b1; end
        drive(); model_reset();
        repeat (2) @(posedge wclk);
        #1 wrst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        wrst = 1'b1; fifo_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pq[i].delete(); en[i] = 1'b1; pq[i].push_back({1'b1, 8'(8'h50 + i)});
        end
        drive();
        @(negedge wclk);
        n_checks++;
        if ({gnt, busy} !== 5'b0) begin
            n_fail++; $display("FAIL reset_gnt_busy got %b %b want 0000 0", gnt, busy);
        end
        n_checks++;
        if ({ack, fifo_write} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ack_write got %b %b want 0000 0", ack, fifo_write);
        end
        do_reset();
    endtask

    task automatic test_two_req();
        do_reset();
        pq[0].push_back({1'b1, 8'hA0});
        pq[2].push_back({1'b1, 8'hA2});
        drive();
        repeat (8) begin
            @(negedge wclk); model_expect(); log_step();
            n_checks++;
            if ({gnt, ack, fifo_write, busy} !== {exp_gnt, exp_ack, exp_write, exp_busy}) begin
                n_fail++;
                $display("FAIL two_req_cycle %0d gnt/ack/wr/busy got %b %b %b %b want %b %b %b %b",
                         cyc, gnt, ack, fifo_write, busy, exp_gnt, exp_ack, exp_write, exp_busy);
            end
            model_advance(); @(posedge wclk); #1; drive();
        end
        n_checks++;
        if (wlog.size() != 2 || wlog[0] !== 8'hA0 || wlog[1] !== 8'hA2) begin
            n_fail++; $display("FAIL two_req_data got %0d writes %p want A0,A2", wlog.size(), wlog);
        end
        n_checks++;
        if (glog.size() != 2 || glog[0] !== 4'b0001 || glog[1] !== 4'b0100) begin
            n_fail++; $display("FAIL two_req_grants got %p want 0001,0100", glog);
        end
        n_checks++;
        if (wcyc.size() != 2 || wcyc[0] != 1 || wcyc[1] != 3) begin
            n_fail++; $display("FAIL two_req_timing got cycles %p want 1,3", wcyc);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] ord [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        do_reset();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 3; k++) pq[i].push_back({1'b1, 4'(i), 4'(k)});
        drive();
        repeat (12) begin
            @(negedge wclk); model_expect(); log_step();
            n_checks++;
            if ({gnt, ack, fifo_write, busy} !== {exp_gnt, exp_ack, exp_write, exp_busy}) begin
                n_fail++;
                $display("FAIL rr_cycle %0d gnt/ack/wr/busy got %b %b %b %b want %b %b %b %b",
                         cyc, gnt, ack, fifo_write, busy, exp_gnt, exp_ack, exp_write, exp_busy);
            end
            if (exp_write) begin
                n_checks++;
                if (fifo_wdata !== exp_wdata) begin
                    n_fail++; $display("FAIL rr_data got %h want %h", fifo_wdata, exp_wdata);
                end
            end
            model_advance(); @(posedge wclk); #1; drive();
        end
        for (int j = 0; j < 6; j++) begin
            n_checks++;
            if (j >= glog.size() || glog[j] !== ord[j]) begin
                n_fail++; $display("FAIL rr_order idx %0d got %p want %b", j, glog, ord[j]);
            end
        end
        n_checks++;
        if (wcyc.size() != 6) begin
            n_fail++; $display("FAIL rr_write_count got %0d want 6", wcyc.size());
        end
        for (int j = 1; j < wcyc.size(); j++) begin
            n_checks++;
            if (wcyc[j] - wcyc[j-1] != 2) begin
                n_fail++; $display("FAIL rr_spacing got %0d want 2", wcyc[j] - wcyc[j-1]);
            end
        end
    endtask

    task automatic test_full_stall();
        int  full_left = 0;
        bit  stalled   = 1'b0;
        do_reset();
        pq[1].push_back({1'b0, 8'h11});
        pq[1].push_back({1'b0, 8'h12});
        pq[1].push_back({1'b1, 8'h13});
        drive();
        repeat (12) begin
            @(negedge wclk); model_expect(); log_step();
            n_checks++;
            if ({gnt, ack, fifo_write, busy} !== {exp_gnt, exp_ack, exp_write, exp_busy}) begin
                n_fail++;
                $display("FAIL full_cycle %0d gnt/ack/wr/busy got %b %b %b %b want %b %b %b %b",
                         cyc, gnt, ack, fifo_write, busy, exp_gnt, exp_ack, exp_write, exp_busy);
            end
            if (fifo_full) begin
                n_checks++;
                if ({gnt, ack, fifo_write} !== 9'b0010_0000_0) begin
                    n_fail++; $display("FAIL full_hold got gnt %b ack %b wr %b want 0010 0000 0",
                                       gnt, ack, fifo_write);
                end
            end
            if (exp_write && !stalled) begin stalled = 1'b1; full_left = 3; end
            model_advance(); @(posedge wclk); #1;
            fifo_full = (full_left > 0);
            if (full_left > 0) full_left--;
            drive();
        end
        n_checks++;
        if (wlog.size() != 3 || wlog[0] !== 8'h11 || wlog[1] !== 8'h12 || wlog[2] !== 8'h13) begin
            n_fail++; $display("FAIL full_data got %p want 11,12,13", wlog);
        end
    endtask

    task automatic test_burst();
`ifdef WARB_BURST_LIMIT_EN
        logic [7:0] ew [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h21, 8'h22, 8'h05, 8'h06};
        logic [3:0] eg [3] = '{4'b0001, 4'b0100, 4'b0001};
`else
        logic [7:0] ew [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h21, 8'h22};
        logic [3:0] eg [2] = '{4'b0001, 4'b0100};
`endif
        do_reset();
        for (int k = 1; k <= 6; k++) pq[0].push_back({k == 6, 8'(k)});
        pq[2].push_back({1'b0, 8'h21});
        pq[2].push_back({1'b1, 8'h22});
        en[2] = 1'b0;
        drive();
        repeat (20) begin
            @(negedge wclk); model_expect(); log_step();
            n_checks++;
            if ({gnt, ack, fifo_write, busy} !== {exp_gnt, exp_ack, exp_write, exp_busy}) begin
                n_fail++;
                $display("FAIL burst_cycle %0d gnt/ack/wr/busy got %b %b %b %b want %b %b %b %b",
                         cyc, gnt, ack, fifo_write, busy, exp_gnt, exp_ack, exp_write, exp_busy);
            end
            model_advance(); @(posedge wclk); #1;
            if (pq[0].size() <= 5) en[2] = 1'b1;
            drive();
        end
        n_checks++;
        if (wlog.size() != 8) begin
            n_fail++; $display("FAIL burst_count got %0d want 8", wlog.size());
        end
        for (int j = 0; j < 8; j++) begin
            n_checks++;
            if (j >= wlog.size() || wlog[j] !== ew[j]) begin
                n_fail++; $display("FAIL burst_order idx %0d got %p want %h", j, wlog, ew[j]);
            end
        end
        n_checks++;
        if (glog.size() != $size(eg)) begin
            n_fail++; $display("FAIL burst_grants got %p want %0d grants", glog, $size(eg));
        end
        for (int j = 0; j < $size(eg); j++) begin
            n_checks++;
            if (j >= glog.size() || glog[j] !== eg[j]) begin
                n_fail++; $display("FAIL burst_grant idx %0d got %p want %b", j, glog, eg[j]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (400) begin
            @(negedge wclk); model_expect(); log_step();
            n_checks++;
            if ({gnt, ack, fifo_write, busy} !== {exp_gnt, exp_ack, exp_write, exp_busy}) begin
                n_fail++;
                $display("FAIL rand_cycle %0d gnt/ack/wr/busy got %b %b %b %b want %b %b %b %b",
                         cyc, gnt, ack, fifo_write, busy, exp_gnt, exp_ack, exp_write, exp_busy);
            end
            if (exp_write) begin
                n_checks++;
                if (fifo_wdata !== exp_wdata) begin
                    n_fail++; $display("FAIL rand_data got %h want %h", fifo_wdata, exp_wdata);
                end
            end
            model_advance(); @(posedge wclk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (pq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    int len = $urandom_range(1, 6);
                    for (int k = 0; k < len; k++) pq[i].push_back({k == len - 1, 8'($urandom)});
                end
                en[i] = ($urandom_range(0, 9) != 0);
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            drive();
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit reached = 1'b0;
        int budget  = 0;
        do_reset();
        for (int k = 1; k <= 4; k++) pq[3].push_back({k == 4, 8'(8'h30 + k)});
        drive();
        while (!reached && budget < 10) begin
            @(negedge wclk); model_expect(); log_step();
            n_checks++;
            if ({gnt, ack, fifo_write, busy} !== {exp_gnt, exp_ack, exp_write, exp_busy}) begin
                n_fail++;
                $display("FAIL rstmid_cycle %0d gnt/ack/wr/busy got %b %b %b %b want %b %b %b %b",
                         cyc, gnt, ack, fifo_write, busy, exp_gnt, exp_ack, exp_write, exp_busy);
            end
            model_advance(); @(posedge wclk); #1; drive();
            reached = (m_owner == 3 && m_cnt == 1);
            budget++;
        end
        n_checks++;
        if (!reached) begin
            n_fail++; $display("FAIL rstmid_wait got no beat after %0d cycles want 1 beat", budget);
        end
        #1;
        n_checks++;
        if ({gnt, fifo_write, fifo_wdata} !== {4'b1000, 1'b1, 8'h32}) begin
            n_fail++; $display("FAIL rstmid_before got gnt %b wr %b data %h want 1000 1 32",
                               gnt, fifo_write, fifo_wdata);
        end
        wrst = 1'b1;
        #1;
        n_checks++;
        if ({gnt, ack, fifo_write, busy} !== 10'b0) begin
            n_fail++; $display("FAIL rstmid_async got gnt %b ack %b wr %b busy %b want all 0",
                               gnt, ack, fifo_write, busy);
        end
        #1 wrst = 1'b0;
        model_reset();
        for (int i = 0; i < NREQ; i++) begin
            pq[i].delete(); en[i] = 1'b1; pq[i].push_back({1'b1, 8'(8'hC0 + i)});
        end
        drive();
        clear_logs();
        repeat (4) begin
            @(negedge wclk); model_expect(); log_step();
            n_checks++;
            if ({gnt, ack, fifo_write, busy} !== {exp_gnt, exp_ack, exp_write, exp_busy}) begin
                n_fail++;
                $display("FAIL rstmid_after %0d gnt/ack/wr/busy got %b %b %b %b want %b %b %b %b",
                         cyc, gnt, ack, fifo_write, busy, exp_gnt, exp_ack, exp_write, exp_busy);
            end
            model_advance(); @(posedge wclk); #1; drive();
        end
        n_checks++;
        if (glog.size() == 0 || glog[0] !== 4'b0001) begin
            n_fail++; $display("FAIL rstmid_first_grant got %p want 0001", glog);
        end
    endtask

    initial begin
        wrst = 1'b1; fifo_full = 1'b0; req = '0; req_data = '0; req_last = '0;
        model_reset(); clear_logs();
        test_reset();
        test_two_req();
        test_round_robin();
        test_full_stall();
        test_burst();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
